// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage.
//   fetch_state_t    : fetch FSM states
//                      START - first cycle after reset, PC settles
//                      REQ   - request presented to instruction memory
//                      WAIT  - request accepted, waiting for the response
//                      DROP  - a redirect superseded the outstanding request;
//                              its response is discarded on arrival
//                      HOLD  - instruction buffered, offered to decode
//   RESET_PC_DEFAULT : PC of the first fetch after reset. It matches the
//                      core's initial-PC constant.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        START,
        REQ,
        WAIT,
        DROP,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage in front of the single-cycle control decoder.
//   Owns the PC, issues one request at a time to instruction memory, buffers
//   the returned word and offers it, together with its PC, to decode until
//   decode takes it. Redirects replace the PC and discard any in-flight
//   response that belongs to the old path.
//
//   Ports
//     clock           : core clock, rising edge
//     reset_n         : asynchronous active-low reset
//     inst_req_valid  : fetch request to instruction memory
//     inst_req_ready  : memory accepts the request this cycle
//     inst_req_addr   : word-aligned fetch address
//     inst_resp_valid : response valid (only while a request is outstanding)
//     inst_resp_data  : instruction word returned by memory
//     inst_valid      : buffered instruction available to decode
//     inst            : buffered instruction (decode takes inst[6:0])
//     inst_pc         : PC of the buffered instruction
//     inst_ready      : decode consumes the instruction this cycle
//     redirect_valid  : control-flow redirect
//     redirect_pc     : redirect target, bits [1:0] ignored
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [31:0] inst_req_addr,
    input  logic        inst_resp_valid,
    input  logic [31:0] inst_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  redirect_target;
    logic         load_inst;
    logic         redirect_lsb_unused;

    // The PC is kept word aligned, so the target's low bits are dropped.
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Outputs are decoded purely from registers, so they fall with reset_n.
    assign inst_req_valid = (state == REQ);
    assign inst_req_addr  = pc;
    assign inst_valid     = (state == HOLD);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        pc_next    = pc;
        load_inst  = 1'b0;

        unique case (state)
            START: begin
                state_next = REQ;
                if (redirect_valid) pc_next = redirect_target;
            end

            REQ: begin
                // The address may move while the request is still pending;
                // once accepted, a redirect means the response is stale.
                if (redirect_valid) pc_next = redirect_target;
                if (inst_req_ready) state_next = redirect_valid ? DROP : WAIT;
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    // A response arriving with the redirect is already stale.
                    state_next = inst_resp_valid ? REQ : DROP;
                end else if (inst_resp_valid) begin
                    load_inst  = 1'b1;
                    state_next = HOLD;
                end
            end

            DROP: begin
                if (redirect_valid) pc_next = redirect_target;
                if (inst_resp_valid) state_next = REQ;
            end

            HOLD: begin
                // A redirect wins over consumption: the buffered word is on
                // the wrong path even if decode takes it this cycle.
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = REQ;
                end else if (inst_ready) begin
                    pc_next    = pc + 32'd4;
                    state_next = REQ;
                end
            end

            default: state_next = START;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= START;
            pc      <= {RESET_PC[31:2], 2'b00};
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state <= state_next;
            pc    <= pc_next;
            if (load_inst) begin
                inst    <= inst_resp_data;
                inst_pc <= pc;
            end
        end
    end

endmodule : fetch_unit
